// File: rtl/scariv_br_upd_queue.sv
// Multi-channel branch-update queue: compacts up to CH records per cycle into a
// circular FIFO and drains one per cycle to the predictor update port.
module scariv_br_upd_queue #(
    parameter int CH       = 2,
    parameter int DEPTH    = 8,
    parameter int W        = 128,
    parameter int BLOCKING = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [CH-1:0]             i_valid,
    input  logic [CH-1:0][W-1:0]      i_payload,
    input  logic [CH-1:0]             i_mispredict,
    output logic                      o_ready,
    input  logic                      i_flush,
    output logic                      o_valid,
    output logic [W-1:0]              o_payload,
    output logic                      o_mispredict,
    input  logic                      i_ready,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [15:0]               o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] CH_P    = PW'(CH);

    logic [PW-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]          count, free_space, allowed, n_valid, written, dropped;
    logic [CH-1:0][PW-1:0]  slot_ofs;
    logic [CH-1:0]          wr_en;
    logic                   pop;
    logic [15:0]            drop_cnt_reg, drop_cnt_next;
    logic [16:0]            drop_sum;
    logic [W:0]             mem [DEPTH];

    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign free_space = DEPTH_P - count;
    assign o_count    = count;
    assign o_valid    = (count != '0);
    assign o_ready    = (BLOCKING != 0) ? (free_space >= CH_P) : 1'b1;
    assign o_drop_cnt = drop_cnt_reg;

    assign {o_mispredict, o_payload} = mem[rd_ptr_reg[AW-1:0]];

    // Each valid channel's slot offset is the number of valid channels below it.
    always_comb begin
        n_valid  = '0;
        slot_ofs = '0;
        for (int c = 0; c < CH; c++) begin
            slot_ofs[c] = n_valid;
            n_valid     = n_valid + PW'(i_valid[c]);
        end
    end

    // Blocking mode accepts the whole set or nothing; drop mode accepts up to the free space.
    assign allowed = (BLOCKING != 0) ? (o_ready ? CH_P : '0) : free_space;
    assign written = i_flush ? '0 : ((n_valid < allowed) ? n_valid : allowed);
    assign dropped = ((BLOCKING != 0) || i_flush) ? '0 : (n_valid - written);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_wr_en
            assign wr_en[gi] = i_valid[gi] && !i_flush && !i_reset && (slot_ofs[gi] < allowed);
        end
    endgenerate

    assign pop         = o_valid && i_ready && !i_flush;
    assign wr_ptr_next = i_flush ? rd_ptr_reg : (wr_ptr_reg + written);
    assign rd_ptr_next = rd_ptr_reg + PW'(pop);

    assign drop_sum      = {1'b0, drop_cnt_reg} + 17'(dropped);
    assign drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Storage is deliberately not reset; the pointers define which slots are live.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CH; c++) begin
            if (wr_en[c]) begin
                mem[wr_ptr_reg[AW-1:0] + slot_ofs[c][AW-1:0]] <= {i_mispredict[c], i_payload[c]};
            end
        end
    end

endmodule
